gpio_arbitro: RTL

GPIO_ARBITRO -- requirements
Module: gpio_arbitro

---
 rtl/gpio_arbitro_if.sv | 22 ++
 rtl/gpio_arbitro.sv | 105 ++++++++++
 2 files changed

// File: rtl/gpio_arbitro_if.sv
// Two-requester write port bundle: core store port (0) and debug port (1).
// The arbiter takes the slave side, the requesters drive the master side.
interface gpio_arbitro_if;
   logic        req0;
   logic [31:0] dir0;
   logic [31:0] datos0;
   logic        ack0;
   logic        req1;
   logic [31:0] dir1;
   logic [31:0] datos1;
   logic        ack1;

   modport master (
      output req0, dir0, datos0, req1, dir1, datos1,
      input  ack0, ack1
   );

   modport slave (
      input  req0, dir0, datos0, req1, dir1, datos1,
      output ack0, ack1
   );
endinterface

// File: rtl/gpio_arbitro.sv
// Round-robin arbiter for two write requesters feeding a GPIO output register
// that only commits after CONFIRMACIONES consecutive writes to DIR_GPIO.
module gpio_arbitro #(
   parameter logic [31:0] DIR_GPIO       = 32'h0000ABCD,
   parameter int          CONFIRMACIONES = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   gpio_arbitro_if.slave        bus,
   output logic [31:0]          salida,
   output logic                 valida,
   output logic                 ocupado
);

   typedef enum logic [1:0] {INACTIVO, CONCEDIDO, LIBERA} estado_t;

   typedef struct packed {
      logic [31:0] dir;
      logic [31:0] datos;
   } pet_t;

   localparam logic [3:0] CONF = 4'(CONFIRMACIONES);

   generate
      if (CONFIRMACIONES < 1 || CONFIRMACIONES > 15) begin : g_conf_chk
         $error("CONFIRMACIONES out of range 1..15");
      end
   endgenerate

   estado_t     estado, estado_sig;
   logic [1:0]  req_v;
   pet_t        pet [2];
   pet_t        lat;
   logic        sel;
   logic        gnt;
   logic        ptr;
   logic [3:0]  cuenta;
   logic [3:0]  cuenta_inc;

   assign req_v      = {bus.req1, bus.req0};
   assign pet[0]     = '{dir: bus.dir0, datos: bus.datos0};
   assign pet[1]     = '{dir: bus.dir1, datos: bus.datos1};
   assign cuenta_inc = cuenta + 4'd1;

   // Contention resolved by ptr; a lone request wins outright.
   assign sel = (req_v == 2'b11) ? ptr : req_v[1];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) estado <= INACTIVO;
      else      estado <= estado_sig;
   end

   always_comb begin
      estado_sig = estado;
      case (estado)
         INACTIVO:  if (|req_v) estado_sig = CONCEDIDO;
         CONCEDIDO: estado_sig = LIBERA;
         LIBERA:    if (!req_v[gnt]) estado_sig = INACTIVO;
         default:   estado_sig = INACTIVO;
      endcase
   end

   always_comb begin
      bus.ack0 = 1'b0;
      bus.ack1 = 1'b0;
      ocupado  = (estado != INACTIVO);
      if (estado == CONCEDIDO) begin
         bus.ack0 = ~gnt;
         bus.ack1 = gnt;
      end
   end

   // Request is captured on the grant edge, so later dir/datos changes are ignored.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         gnt    <= 1'b0;
         ptr    <= 1'b0;
         lat    <= '0;
         cuenta <= '0;
         salida <= '0;
         valida <= 1'b0;
      end else begin
         valida <= 1'b0;
         if (estado == INACTIVO && |req_v) begin
            gnt <= sel;
            ptr <= ~sel;
            lat <= pet[sel];
         end
         if (estado == CONCEDIDO) begin
            if (lat.dir == DIR_GPIO) begin
               if (cuenta_inc == CONF) begin
                  salida <= lat.datos;
                  cuenta <= '0;
                  valida <= 1'b1;
               end else begin
                  cuenta <= cuenta_inc;
               end
            end else begin
               cuenta <= '0;
            end
         end
      end
   end

endmodule
